lane_pulse_emitter: RTL and testbench

- Transmit-side counterpart to the per-lane event counters: takes a labelled event count and replays it as one-hot pulses on a bank of 1-bit lanes, round-robin, one pulse per cycle.
- Each request carries a partition bit that selects the security label of the count and the emitted pulses (0 = L, 1 = H).
- For H requests the busy time is padded to a constant length, so completion timing reveals nothing about the H count.

---
 rtl/lane_pulse_emitter.sv | 143 ++++++++++++++
 tb/tb_lane_pulse_emitter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/lane_pulse_emitter.sv
// lane_pulse_emitter: replays a labelled event count as one-hot pulses on a
// bank of lanes, round-robin, one pulse per cycle. H-labelled requests are
// padded to a constant busy length so completion timing hides the count.
module lane_pulse_emitter #(
    parameter int LANES   = 4,
    parameter int CW      = 4,
    parameter int FIX_LEN = 2**CW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_par,
    input  logic [CW-1:0]    req_cnt,
    input  logic             abort,
    output logic [LANES-1:0] ev,
    output logic             ev_par,
    output logic             done
);

    localparam int PW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int EW = $clog2(FIX_LEN + 1);
    // Elapsed value of the last cycle before done is shown for H requests.
    localparam logic [EW-1:0] PAD_LAST = EW'(FIX_LEN - 1);
    localparam logic [LANES-1:0] LANE0 = LANES'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EMIT,
        S_PAD,
        S_DONE
    } state_t;

    state_t           r_state;
    // Pulses still owed after the one currently shown on ev.
    logic [CW-1:0]    r_remaining;
    logic [PW-1:0]    r_ptr;
    logic [EW-1:0]    r_elapsed;
    logic [LANES-1:0] r_ev;
    logic             r_ev_par;
    logic             r_done;
    logic             r_ready;

    logic [LANES-1:0] w_lane;
    logic [EW-1:0]    w_elapsed_inc;
    logic             w_pad_end;

    // Next lane pulse, saturating elapsed count and H padding end detection.
    always_comb begin
        w_lane        = LANE0 << r_ptr;
        w_elapsed_inc = (r_elapsed == {EW{1'b1}}) ? r_elapsed : r_elapsed + EW'(1);
        w_pad_end     = (r_elapsed >= PAD_LAST);
    end

    // Request FSM; every output is registered alongside the state so that the
    // value seen during a cycle belongs to the state of that cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_remaining <= '0;
            r_ptr       <= '0;
            r_elapsed   <= '0;
            r_ev        <= '0;
            r_ev_par    <= 1'b0;
            r_done      <= 1'b0;
            r_ready     <= 1'b1;
        end else if ((r_state != S_IDLE) && abort) begin
            // NOTE: non-blocking assignments keep every register update in this
            // block reading the pre-edge values, whatever the statement order.
            r_state <= S_IDLE;
            r_ev    <= '0;
            r_done  <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_ev_par  <= req_par;
                        r_elapsed <= EW'(1);
                        r_ready   <= 1'b0;
                        if (req_cnt != '0) begin
                            // First pulse goes out in the cycle right after acceptance.
                            r_state     <= S_EMIT;
                            r_ev        <= LANE0;
                            r_ptr       <= PW'(1);
                            r_remaining <= req_cnt - CW'(1);
                        end else begin
                            r_ev        <= '0;
                            r_ptr       <= '0;
                            r_remaining <= '0;
                            if (req_par && (PAD_LAST > EW'(1))) begin
                                r_state <= S_PAD;
                            end else begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                            end
                        end
                    end
                end
                S_EMIT: begin
                    r_elapsed <= w_elapsed_inc;
                    if (r_remaining != '0) begin
                        r_ev        <= w_lane;
                        r_ptr       <= r_ptr + PW'(1);
                        r_remaining <= r_remaining - CW'(1);
                    end else begin
                        r_ev <= '0;
                        if (!r_ev_par || w_pad_end) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_PAD;
                        end
                    end
                end
                S_PAD: begin
                    r_elapsed <= w_elapsed_inc;
                    if (w_pad_end) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ev    <= '0;
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready = r_ready;
    assign ev        = r_ev;
    assign ev_par    = r_ev_par;
    assign done      = r_done;

endmodule

// File: tb/tb_lane_pulse_emitter.sv
// Testbench for lane_pulse_emitter: table-driven requests with a per-cycle
// scoreboard of expected outputs, plus hand-written reset/abort/back-to-back
// sequences.
module tb_lane_pulse_emitter;

    localparam int LANES   = 4;
    localparam int CW      = 4;
    localparam int FIX_LEN = 16;

    logic             clk;
    logic             reset;
    logic             req_valid;
    logic             req_ready;
    logic             req_par;
    logic [CW-1:0]    req_cnt;
    logic             abort;
    logic [LANES-1:0] ev;
    logic             ev_par;
    logic             done;

    int n_checks = 0;
    int n_errors = 0;

    // Packed view of the outputs: {req_ready, done, ev_par, ev}.
    typedef logic [6:0] obs_t;
    obs_t sb_q[$];

    typedef struct {
        logic          par;
        logic [CW-1:0] cnt;
        int            done_off;   // cycle of done relative to accept edge
    } vec_t;

    lane_pulse_emitter #(.LANES(LANES), .CW(CW), .FIX_LEN(FIX_LEN)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_par   (req_par),
        .req_cnt   (req_cnt),
        .abort     (abort),
        .ev        (ev),
        .ev_par    (ev_par),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic obs_t pack(logic rdy, logic dn, logic par, logic [LANES-1:0] e);
        return {rdy, dn, par, e};
    endfunction

    function automatic obs_t actual();
        return {req_ready, done, ev_par, ev};
    endfunction

    // Expected outputs in cycle k (1-based) after a request is accepted.
    function automatic obs_t trace_entry(logic par, int cnt, int done_off, int k);
        logic [LANES-1:0] one;
        logic [LANES-1:0] e;
        one = 4'b0001;
        e   = (k <= cnt) ? (one << ((k - 1) % LANES)) : '0;
        return pack(k == done_off + 1, k == done_off, par, e);
    endfunction

    task automatic check(string name, obs_t act, obs_t exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b ({ready,done,ev_par,ev})", name, act, exp);
        end
    endtask

    task automatic push_trace(logic par, int cnt, int done_off);
        for (int k = 1; k <= done_off + 1; k++) sb_q.push_back(trace_entry(par, cnt, done_off, k));
    endtask

    // Present a request for one edge; returns just after the accept edge.
    task automatic start_req(logic par, logic [CW-1:0] cnt);
        @(negedge clk);
        check("ready before request", {req_ready, 6'b0}, {1'b1, 6'b0});
        req_valid = 1'b1;
        req_par   = par;
        req_cnt   = cnt;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_par   = 1'($urandom_range(1));
        req_cnt   = CW'($urandom_range(15));
    endtask

    // Pop and compare one scoreboard entry per cycle; also checks that ev_par
    // only changes after a cycle with ev idle.
    task automatic drain(string tag, int n);
        obs_t             exp;
        logic             prev_par;
        logic [LANES-1:0] prev_ev;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL %s: scoreboard empty at cycle %0d", tag, i + 1);
            end else begin
                exp = sb_q.pop_front();
                check($sformatf("%s cycle %0d", tag, i + 1), actual(), exp);
            end
            if (i > 0 && ev_par !== prev_par)
                check($sformatf("%s ev_par change after idle ev", tag), {3'b0, prev_ev}, 7'b0);
            prev_par = ev_par;
            prev_ev  = ev;
        end
    endtask

    initial begin
        vec_t vecs[7];
        vecs[0] = '{par: 1'b0, cnt: 4'd6,  done_off: 7};
        vecs[1] = '{par: 1'b1, cnt: 4'd3,  done_off: 16};
        vecs[2] = '{par: 1'b1, cnt: 4'd15, done_off: 16};
        vecs[3] = '{par: 1'b0, cnt: 4'd0,  done_off: 1};
        vecs[4] = '{par: 1'b1, cnt: 4'd0,  done_off: 16};
        vecs[5] = '{par: 1'b0, cnt: 4'd1,  done_off: 2};
        vecs[6] = '{par: 1'b0, cnt: 4'd15, done_off: 16};

        reset     = 1'b0;
        req_valid = 1'b0;
        req_par   = 1'b0;
        req_cnt   = '0;
        abort     = 1'b0;

        // Reset state while held in reset.
        repeat (2) @(negedge clk);
        check("reset state", actual(), pack(1'b1, 1'b0, 1'b0, 4'b0000));
        reset = 1'b1;

        // Table-driven requests.
        foreach (vecs[v]) begin
            start_req(vecs[v].par, vecs[v].cnt);
            push_trace(vecs[v].par, int'(vecs[v].cnt), vecs[v].done_off);
            drain($sformatf("vec%0d", v), vecs[v].done_off + 1);
        end

        // Reset low during the third pulse of an L cnt=9 request.
        start_req(1'b0, 4'd9);
        for (int k = 1; k <= 3; k++) sb_q.push_back(trace_entry(1'b0, 9, 10, k));
        drain("pre-reset", 3);
        reset = 1'b0;
        #1;
        check("async reset mid-emit", actual(), pack(1'b1, 1'b0, 1'b0, 4'b0000));
        @(negedge clk);
        check("held reset no done", actual(), pack(1'b1, 1'b0, 1'b0, 4'b0000));
        reset = 1'b1;
        start_req(1'b0, 4'd1);
        push_trace(1'b0, 1, 2);
        drain("post-reset", 3);

        // Abort at t+2 of L cnt=10, with a new request held during busy.
        start_req(1'b0, 4'd10);
        req_valid = 1'b1;
        req_par   = 1'b1;
        req_cnt   = 4'd5;
        @(negedge clk);
        check("abort t+1", actual(), pack(1'b0, 1'b0, 1'b0, 4'b0001));
        @(negedge clk);
        check("abort t+2", actual(), pack(1'b0, 1'b0, 1'b0, 4'b0010));
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort t+3", actual(), pack(1'b1, 1'b0, 1'b0, 4'b0000));
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        push_trace(1'b1, 5, FIX_LEN);
        drain("held H5", FIX_LEN + 1);

        // abort together with req_valid in IDLE: request still accepted.
        @(negedge clk);
        abort     = 1'b1;
        req_valid = 1'b1;
        req_par   = 1'b0;
        req_cnt   = 4'd2;
        @(posedge clk);
        #1;
        abort     = 1'b0;
        req_valid = 1'b0;
        push_trace(1'b0, 2, 3);
        drain("idle abort", 4);

        // Back-to-back: L cnt=2 then H cnt=1 waiting for the first req_ready.
        start_req(1'b0, 4'd2);
        req_valid = 1'b1;
        req_par   = 1'b1;
        req_cnt   = 4'd1;
        push_trace(1'b0, 2, 3);
        push_trace(1'b1, 1, FIX_LEN);
        drain("b2b first", 4);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        drain("b2b second", FIX_LEN + 1);

        if (sb_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard leftover: got %0d entries expected 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
